// File: rtl/sin_pwm_dac.sv
// sin_pwm_dac: PWM output stage of the sine generator; each accepted sample sets the duty of one full PWM period.
// Define PWM_COMPL_EN to add the complementary pwm_n output with dead-time insertion.
module sin_pwm_dac #(
    parameter int DATA_W   = 8,
    parameter int PRESCALE = 1,
    parameter int DEAD     = 2
) (
    input  logic              clk,
    input  logic              res,
    input  logic              en,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ack,
    output logic              pwm_out,
    output logic              pwm_n,
    output logic [7:0]        underrun_cnt
);

    localparam int                PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]   PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [DATA_W-1:0] CNT_LAST = '1;

    if (PRESCALE < 1 || DEAD > 32) begin : g_param_check
        $error("sin_pwm_dac: PRESCALE must be >= 1 and DEAD must be <= 32");
    end

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state, state_d;
    logic [PS_W-1:0]   presc, presc_d;
    logic [DATA_W-1:0] pwm_cnt, pwm_cnt_d;
    logic [DATA_W-1:0] duty_q, duty_d;
    logic [7:0]        underrun_d;
    logic              ack_d;
    logic              pwm_d;
    logic              tick;
    logic              boundary;

    assign tick     = (presc == PS_LAST);
    assign boundary = tick && (pwm_cnt == CNT_LAST);

    // Duty is only ever reloaded on the last tick of a period, so a period never changes shape mid-way.
    always_comb begin
        state_d    = state;
        presc_d    = presc;
        pwm_cnt_d  = pwm_cnt;
        duty_d     = duty_q;
        underrun_d = underrun_cnt;
        ack_d      = 1'b0;
        pwm_d      = 1'b0;
        case (state)
            IDLE: begin
                presc_d   = '0;
                pwm_cnt_d = '0;
                if (en && sample_valid) begin
                    duty_d  = sample_in;
                    ack_d   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d   = IDLE;
                    presc_d   = '0;
                    pwm_cnt_d = '0;
                end else begin
                    pwm_d   = (pwm_cnt < duty_q);
                    presc_d = tick ? '0 : presc + 1'b1;
                    if (tick) begin
                        pwm_cnt_d = pwm_cnt + 1'b1;
                    end
                    if (boundary) begin
                        if (sample_valid) begin
                            duty_d = sample_in;
                            ack_d  = 1'b1;
                        end else if (underrun_cnt != 8'hFF) begin
                            underrun_d = underrun_cnt + 8'd1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state        <= IDLE;
            presc        <= '0;
            pwm_cnt      <= '0;
            duty_q       <= '0;
            underrun_cnt <= '0;
            sample_ack   <= 1'b0;
            pwm_out      <= 1'b0;
        end else begin
            state        <= state_d;
            presc        <= presc_d;
            pwm_cnt      <= pwm_cnt_d;
            duty_q       <= duty_d;
            underrun_cnt <= underrun_d;
            sample_ack   <= ack_d;
            pwm_out      <= pwm_d;
        end
    end

`ifdef PWM_COMPL_EN
    localparam int               POS_W     = DATA_W + PS_W + 1;
    localparam logic [POS_W-1:0] PRE_START = POS_W'((2 ** DATA_W) * PRESCALE - DEAD);
    localparam logic [4:0]       DEAD_LD   = (DEAD > 0) ? 5'(DEAD - 1) : 5'd0;

    logic [POS_W-1:0] pos;
    logic [4:0]       dead_cnt;
    logic             pre_rise;

    // pwm_out can only rise at a period start, so the pre-rise gap is taken from the clock position in the period.
    assign pos      = POS_W'(pwm_cnt) * POS_W'(PRESCALE) + POS_W'(presc);
    assign pre_rise = (duty_q != '0) && (pos >= PRE_START);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            dead_cnt <= '0;
            pwm_n    <= 1'b0;
        end else if (state != RUN || state_d != RUN) begin
            dead_cnt <= DEAD_LD;
            pwm_n    <= 1'b0;
        end else if (pwm_d != pwm_out) begin
            dead_cnt <= DEAD_LD;
            pwm_n    <= (DEAD == 0) && !pwm_d;
        end else if (pwm_d || pre_rise) begin
            pwm_n    <= 1'b0;
        end else if (dead_cnt != '0) begin
            dead_cnt <= dead_cnt - 1'b1;
            pwm_n    <= 1'b0;
        end else begin
            pwm_n    <= 1'b1;
        end
    end
`else
    assign pwm_n = 1'b0;
`endif

endmodule

// File: tb/tb_sin_pwm_dac.sv
// Self-checking bench for sin_pwm_dac: period-by-period duty scoreboard plus directed handshake/reset steps.
module tb_sin_pwm_dac;

    localparam int PERIOD1 = 256;
    localparam int PERIOD4 = 1024;
`ifdef PWM_COMPL_EN
    localparam int EXP_N4 = 508;
`else
    localparam int EXP_N4 = 0;
`endif

    logic       clk = 1'b0;
    logic       res;
    logic       en;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ack;
    logic       pwm_out;
    logic       pwm_n;
    logic [7:0] underrun_cnt;

    logic       en4 = 1'b1;
    logic [7:0] sample4 = 8'h80;
    logic       valid4 = 1'b1;
    logic       sample_ack4;
    logic       pwm_out4;
    logic       pwm_n4;
    logic [7:0] underrun_cnt4;

    int tests_run = 0;
    int tests_failed = 0;
    int exp_q[$];
    int cur;
    int acks;

    sin_pwm_dac #(.DATA_W(8), .PRESCALE(1), .DEAD(2)) dut (
        .clk(clk), .res(res), .en(en), .sample_in(sample_in), .sample_valid(sample_valid),
        .sample_ack(sample_ack), .pwm_out(pwm_out), .pwm_n(pwm_n), .underrun_cnt(underrun_cnt)
    );

    sin_pwm_dac #(.DATA_W(8), .PRESCALE(4), .DEAD(2)) dut4 (
        .clk(clk), .res(res), .en(en4), .sample_in(sample4), .sample_valid(valid4),
        .sample_ack(sample_ack4), .pwm_out(pwm_out4), .pwm_n(pwm_n4), .underrun_cnt(underrun_cnt4)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic v, input logic [7:0] s);
        en           = e;
        sample_valid = v;
        sample_in    = s;
    endtask

    task automatic waitAck(input string tag, input int exp_clks);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_ack && n < 2000);
        checkOutput(tag, n, exp_clks);
    endtask

    // Window of one period starts on the sample after an ack and spans a full PWM period.
    int   win_n1 = 0, win_hi1 = 0, exp_v;
    bit   active1 = 0;
    logic prev_ack1 = 1'b0;
    always @(negedge clk) begin
        if (!res || !en) begin
            active1 = 0;
            win_n1  = 0;
            win_hi1 = 0;
        end else begin
            if (active1) begin
                win_hi1 += int'(pwm_out);
                win_n1++;
                if (win_n1 == PERIOD1) begin
                    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    checkOutput("period_high", win_hi1, exp_v);
                    win_n1  = 0;
                    win_hi1 = 0;
                end
            end
            if (sample_ack) begin
                checkOutput("ack_single", prev_ack1, 0);
                active1 = 1;
                win_n1  = 0;
                win_hi1 = 0;
            end
        end
        prev_ack1 = sample_ack;
    end

    int win_n4 = 0, hi4 = 0, nhi4 = 0, ovl4 = 0;
    bit active4 = 0;
    always @(negedge clk) begin
        if (!res) begin
            active4 = 0;
            win_n4  = 0;
            hi4     = 0;
            nhi4    = 0;
            ovl4    = 0;
        end else begin
            if (active4) begin
                hi4  += int'(pwm_out4);
                nhi4 += int'(pwm_n4);
                ovl4 += int'(pwm_out4 & pwm_n4);
                win_n4++;
                if (win_n4 == PERIOD4) begin
                    checkOutput("p4_pwm_high", hi4, 512);
                    checkOutput("p4_pwmn_high", nhi4, EXP_N4);
                    checkOutput("p4_overlap", ovl4, 0);
                    win_n4 = 0;
                    hi4    = 0;
                    nhi4   = 0;
                    ovl4   = 0;
                end
            end
            if (sample_ack4) begin
                active4 = 1;
                win_n4  = 0;
                hi4     = 0;
                nhi4    = 0;
                ovl4    = 0;
            end
        end
    end

    initial begin
        res = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        checkOutput("rst_ack", sample_ack, 0);
        checkOutput("rst_pwm", pwm_out, 0);
        checkOutput("rst_pwm_n", pwm_n, 0);
        checkOutput("rst_underrun", underrun_cnt, 0);
        res = 1'b1;
        @(negedge clk);

        // Steady 25% duty with ack once per period
        applyStimulus(1'b1, 1'b1, 8'h40);
        cur = 8'h40;
        waitAck("t1_first_ack", 1);
        exp_q.push_back(cur);
        repeat (2) begin
            waitAck("t1_ack_period", PERIOD1);
            exp_q.push_back(cur);
        end

        // Duty extremes
        applyStimulus(1'b1, 1'b1, 8'h00);
        cur = 0;
        waitAck("t2_ack_00", PERIOD1);
        exp_q.push_back(cur);
        applyStimulus(1'b1, 1'b1, 8'hFF);
        cur = 255;
        waitAck("t2_ack_ff", PERIOD1);
        exp_q.push_back(cur);

        // Underrun: duty held across three starved boundaries
        applyStimulus(1'b1, 1'b1, 8'h80);
        cur = 128;
        waitAck("t3_ack_80", PERIOD1);
        exp_q.push_back(cur);
        applyStimulus(1'b1, 1'b0, 8'h80);
        repeat (3) exp_q.push_back(128);
        acks = 0;
        repeat (3 * PERIOD1) begin
            @(negedge clk);
            acks += int'(sample_ack);
        end
        checkOutput("t3_no_ack", acks, 0);
        checkOutput("t3_underrun", underrun_cnt, 3);
        applyStimulus(1'b1, 1'b1, 8'h80);
        waitAck("t3_resume_ack", PERIOD1);
        exp_q.push_back(cur);

        // Mid-period sample change only takes effect at the next boundary
        repeat (100) @(negedge clk);
        applyStimulus(1'b1, 1'b1, 8'hC0);
        cur = 192;
        waitAck("t4_ack_mid", PERIOD1 - 100);
        exp_q.push_back(cur);
        waitAck("t4_ack_next", PERIOD1);
        exp_q.push_back(cur);

        // Asynchronous reset at pwm_cnt=100
        repeat (100) @(negedge clk);
        checkOutput("t5_pwm_before_rst", pwm_out, 1);
        res = 1'b0;
        #1;
        checkOutput("t5_rst_pwm", pwm_out, 0);
        checkOutput("t5_rst_ack", sample_ack, 0);
        checkOutput("t5_rst_underrun", underrun_cnt, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        res = 1'b1;
        waitAck("t5_fresh_ack", 1);
        exp_q.push_back(cur);

        // One underrun, then en drop mid-period
        applyStimulus(1'b1, 1'b0, 8'hC0);
        repeat (PERIOD1 + 50) @(negedge clk);
        checkOutput("t5_pwm_before_en", pwm_out, 1);
        applyStimulus(1'b0, 1'b0, 8'hC0);
        exp_q.delete();
        @(negedge clk);
        checkOutput("t5_en_pwm", pwm_out, 0);
        checkOutput("t5_en_ack", sample_ack, 0);
        checkOutput("t5_en_underrun_kept", underrun_cnt, 1);
        repeat (3) @(negedge clk);
        checkOutput("t5_idle_pwm", pwm_out, 0);
        applyStimulus(1'b1, 1'b1, 8'h20);
        cur = 32;
        waitAck("t5_reenable_ack", 1);
        exp_q.push_back(cur);
        waitAck("t5_final_ack", PERIOD1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 8'h00);
        @(negedge clk);
        checkOutput("sb_drained", exp_q.size(), 0);
        checkOutput("p4_underrun", underrun_cnt4, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
